// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default frame parameters and
// the oversampling factor used by both the receive and transmit paths.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int DBIT_DEFAULT    = 8;
    localparam int SB_TICK_DEFAULT = 16;
    localparam int OVERSAMPLE      = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through synchronous FIFO with registered full/empty flags;
// the head word is presented on dout whenever empty is low.
module uart_sync_fifo #(
    parameter int DW = 8,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] din,
    input  logic          wr_en,
    input  logic          rd_en,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);

    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic          push;
    logic          pop;

    // A write while full is dropped even when a pop frees a slot this cycle.
    assign push = wr_en && !full;
    assign pop  = rd_en && !empty;
    assign dout = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + 1'b1;
        else if (pop && !push)
            count_next = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            full  <= (count_next == DEPTH[AW:0]);
            empty <= (count_next == '0);
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: host bytes queue in a FWFT FIFO and are
// serialized as start / DBIT data (LSB first) / stop frames on the s_tick grid.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int DBIT    = DBIT_DEFAULT,
    parameter int SB_TICK = SB_TICK_DEFAULT,
    parameter int FIFO_AW = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_tick,
    input  logic [DBIT-1:0] w_data,
    input  logic            wr_uart,
    output logic            tx_full,
    output logic            tx_empty,
    output logic            tx_busy,
    output logic            tx_done_tick,
    output logic            tx
);

    localparam int SW = $clog2(max_int(SB_TICK, OVERSAMPLE));
    localparam int NW = max_int($clog2(DBIT), 1);

    localparam logic [SW-1:0] S_LAST    = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] STOP_LAST = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST    = NW'(DBIT - 1);

    uart_state_t     state;
    logic [SW-1:0]   s_cnt;
    logic [NW-1:0]   n_cnt;
    logic [DBIT-1:0] b_reg;
    logic [DBIT-1:0] fifo_dout;
    logic            tx_reg;
    logic            done_reg;
    logic            fifo_pop;

    // Popping straight from IDLE keeps the idle gap between frames to one clk.
    assign fifo_pop     = (state == IDLE) && !tx_empty;
    assign tx_busy      = (state != IDLE);
    assign tx_done_tick = done_reg;
    assign tx           = tx_reg;

    uart_sync_fifo #(
        .DW(DBIT),
        .AW(FIFO_AW)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .din  (w_data),
        .wr_en(wr_uart),
        .rd_en(fifo_pop),
        .dout (fifo_dout),
        .full (tx_full),
        .empty(tx_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            s_cnt    <= '0;
            n_cnt    <= '0;
            b_reg    <= '0;
            tx_reg   <= 1'b1;
            done_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state)
                IDLE: begin
                    tx_reg <= 1'b1;
                    if (!tx_empty) begin
                        b_reg  <= fifo_dout;
                        s_cnt  <= '0;
                        tx_reg <= 1'b0;
                        state  <= START;
                    end
                end
                START: begin
                    if (s_tick) begin
                        if (s_cnt == S_LAST) begin
                            s_cnt  <= '0;
                            n_cnt  <= '0;
                            tx_reg <= b_reg[0];
                            state  <= DATA;
                        end else begin
                            s_cnt <= s_cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (s_cnt == S_LAST) begin
                            // tx_reg is registered, so it takes the bit that
                            // lands in b_reg[0] after this shift.
                            b_reg <= {1'b0, b_reg[DBIT-1:1]};
                            s_cnt <= '0;
                            if (n_cnt == N_LAST) begin
                                tx_reg <= 1'b1;
                                state  <= STOP;
                            end else begin
                                n_cnt  <= n_cnt + 1'b1;
                                tx_reg <= b_reg[1];
                            end
                        end else begin
                            s_cnt <= s_cnt + 1'b1;
                        end
                    end
                end
                STOP: begin
                    tx_reg <= 1'b1;
                    if (s_tick) begin
                        if (s_cnt == STOP_LAST) begin
                            done_reg <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            s_cnt <= s_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: frame table, reference receiver
// with expected-byte queue, and hand sequences for FIFO/reset corner cases.
module tb_uart_tx_buffered;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_tick;
    logic [7:0] w_data;
    logic       wr_uart;
    logic       tx_full, tx_empty, tx_busy, tx_done_tick, tx;
    logic [7:0] w_data32;
    logic       wr32;
    logic       full32, empty32, busy32, done32, tx32;

    int         errors = 0;
    int         checks = 0;
    int         done_total = 0;
    int         frames_expected = 0;
    int         rst_count = 0;
    int         tick_div = 0;
    logic [7:0] sb[$];

    typedef struct {
        logic [7:0] data;
        logic [9:0] line;   // line[i] = i-th bit on the wire (start first)
    } vec_t;
    vec_t vecs[5];

    always #5 clk = ~clk;

    uart_tx_buffered dut (
        .clk         (clk),
        .rst         (rst),
        .s_tick      (s_tick),
        .w_data      (w_data),
        .wr_uart     (wr_uart),
        .tx_full     (tx_full),
        .tx_empty    (tx_empty),
        .tx_busy     (tx_busy),
        .tx_done_tick(tx_done_tick),
        .tx          (tx)
    );

    uart_tx_buffered #(.SB_TICK(32)) dut32 (
        .clk         (clk),
        .rst         (rst),
        .s_tick      (s_tick),
        .w_data      (w_data32),
        .wr_uart     (wr32),
        .tx_full     (full32),
        .tx_empty    (empty32),
        .tx_busy     (busy32),
        .tx_done_tick(done32),
        .tx          (tx32)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic write_byte(input logic [7:0] d, input bit expect_sent);
        @(negedge clk);
        w_data  = d;
        wr_uart = 1'b1;
        if (expect_sent) begin
            sb.push_back(d);
            frames_expected++;
        end
    endtask

    task automatic wait_done(input string name, input int limit);
        bit got = 1'b0;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (tx_done_tick === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        check(name, 32'(got), 32'd1);
    endtask

    // Baud tick every 4 clk, driven away from the active edge.
    initial begin
        s_tick = 1'b0;
        forever begin
            @(negedge clk);
            tick_div = tick_div + 1;
            s_tick   = (tick_div % 4 == 0);
        end
    end

    always @(posedge clk) if (rst === 1'b1) rst_count <= rst_count + 1;
    always @(negedge clk) if (tx_done_tick === 1'b1) done_total <= done_total + 1;

    // Reference receiver: samples mid-bit at 64 clk/bit; frames cut by reset are discarded.
    initial begin : rx_model
        logic [9:0] bits;
        logic [7:0] exp_b;
        int         r0;
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                r0 = rst_count;
                for (int b = 0; b < 10; b++) begin
                    repeat ((b == 0) ? 32 : 64) @(negedge clk);
                    bits[b] = tx;
                end
                if (rst_count == r0) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rx_unexpected: got byte 0x%02h, expected no frame", bits[8:1]);
                    end else begin
                        exp_b = sb.pop_front();
                        check("rx_byte", 32'(bits[8:1]), 32'(exp_b));
                        check("rx_start_bit", 32'(bits[0]), 32'd0);
                        check("rx_stop_bit", 32'(bits[9]), 32'd1);
                    end
                end
            end
        end
    end

    initial begin
        #(60000 * 10);
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin : main
        int   d0;
        int   first_rise;
        int   lowc;
        int   last_rise;
        int   done_at;
        logic prev;
        int   edges[$];

        vecs[0] = '{8'hA5, 10'b1101001010};
        vecs[1] = '{8'h00, 10'b1000000000};
        vecs[2] = '{8'hFF, 10'b1111111110};
        vecs[3] = '{8'h3C, 10'b1001111000};
        vecs[4] = '{8'h81, 10'b1100000010};

        rst = 1'b1; wr_uart = 1'b0; w_data = '0; wr32 = 1'b0; w_data32 = '0;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_empty", 32'(tx_empty), 32'd1);
        check("rst_full", 32'(tx_full), 32'd0);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_done", 32'(tx_done_tick), 32'd0);
        check("rst32_state", 32'({tx32, empty32, full32, busy32, done32}), 32'b11000);
        rst = 1'b0;

        lowc = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_empty !== 1'b1 || tx_busy !== 1'b0 || tx_done_tick !== 1'b0)
                lowc++;
        end
        check("idle_200_bad_cycles", 32'(lowc), 32'd0);

        // Frame table: per-bit line check at bit centres plus bit-length checks.
        for (int v = 0; v < 5; v++) begin
            d0 = done_total;
            write_byte(vecs[v].data, 1'b1);
            @(negedge clk);
            wr_uart = 1'b0;
            check($sformatf("empty_cycle1_%02h", vecs[v].data), 32'(tx_empty), 32'd0);
            check($sformatf("tx_idle_cycle1_%02h", vecs[v].data), 32'(tx), 32'd1);
            @(negedge clk);
            check($sformatf("tx_start_cycle2_%02h", vecs[v].data), 32'(tx), 32'd0);
            check($sformatf("busy_cycle2_%02h", vecs[v].data), 32'(tx_busy), 32'd1);
            check($sformatf("empty_cycle2_%02h", vecs[v].data), 32'(tx_empty), 32'd1);
            first_rise = 0;
            prev = 1'b0;
            edges.delete();
            for (int idx = 1; idx <= 608; idx++) begin
                @(negedge clk);
                if (first_rise == 0 && tx === 1'b1) first_rise = idx;
                if (tx !== prev) edges.push_back(idx);
                prev = tx;
                if (idx >= 32 && (idx - 32) % 64 == 0)
                    check($sformatf("line_%02h_bit%0d", vecs[v].data, (idx - 32) / 64),
                          32'(tx), 32'(vecs[v].line[(idx - 32) / 64]));
            end
            if (vecs[v].line[1])
                check_range($sformatf("start_len_%02h", vecs[v].data), first_rise, 61, 64);
            for (int i = 1; i < edges.size(); i++)
                check($sformatf("bit_len_%02h_%0d", vecs[v].data, i),
                      32'((edges[i] - edges[i-1]) % 64), 32'd0);
            wait_done($sformatf("done_seen_%02h", vecs[v].data), 100);
            check("busy_at_done", 32'(tx_busy), 32'd0);
            check("tx_at_done", 32'(tx), 32'd1);
            repeat (2) @(negedge clk);
            check($sformatf("done_once_%02h", vecs[v].data), 32'(done_total - d0), 32'd1);
        end

        // Back-to-back frames: one idle-high clk between stop and next start.
        write_byte(8'h00, 1'b1);
        write_byte(8'hFF, 1'b1);
        write_byte(8'h3C, 1'b1);
        @(negedge clk);
        wr_uart = 1'b0;
        wait_done("b2b_done1", 800);
        check("b2b_gap1_tx", 32'(tx), 32'd1);
        check("b2b_gap1_busy", 32'(tx_busy), 32'd0);
        @(negedge clk);
        check("b2b_start2_tx", 32'(tx), 32'd0);
        check("b2b_start2_empty", 32'(tx_empty), 32'd0);
        wait_done("b2b_done2", 800);
        check("b2b_gap2_tx", 32'(tx), 32'd1);
        check("b2b_gap2_empty", 32'(tx_empty), 32'd0);
        @(negedge clk);
        check("b2b_start3_tx", 32'(tx), 32'd0);
        check("b2b_empty_on_third", 32'(tx_empty), 32'd1);
        wait_done("b2b_done3", 800);

        // Fill FIFO behind an in-flight frame, then a dropped write.
        write_byte(8'h11, 1'b1);
        @(negedge clk);
        wr_uart = 1'b0;
        repeat (2) @(negedge clk);
        check("fill_busy", 32'(tx_busy), 32'd1);
        check("fill_empty", 32'(tx_empty), 32'd1);
        write_byte(8'h22, 1'b1);
        write_byte(8'h33, 1'b1);
        write_byte(8'h44, 1'b1);
        @(negedge clk);
        check("full_before_4th", 32'(tx_full), 32'd0);
        w_data = 8'h55;
        sb.push_back(8'h55);
        frames_expected++;
        @(negedge clk);
        check("full_on_5th_write", 32'(tx_full), 32'd1);
        w_data = 8'h77;
        @(negedge clk);
        wr_uart = 1'b0;
        check("full_after_drop", 32'(tx_full), 32'd1);
        for (int f = 0; f < 5; f++)
            wait_done($sformatf("fill_done%0d", f), 800);
        repeat (2) @(negedge clk);
        check("fill_drained_busy", 32'(tx_busy), 32'd0);
        check("fill_drained_empty", 32'(tx_empty), 32'd1);

        // Reset in the middle of the 2nd of 3 queued frames.
        write_byte(8'hAA, 1'b1);
        write_byte(8'hBB, 1'b1);
        write_byte(8'hCC, 1'b1);
        @(negedge clk);
        wr_uart = 1'b0;
        wait_done("rst_seq_done1", 800);
        repeat (300) @(negedge clk);
        check("busy_mid_data", 32'(tx_busy), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_tx", 32'(tx), 32'd1);
        check("midrst_empty", 32'(tx_empty), 32'd1);
        check("midrst_busy", 32'(tx_busy), 32'd0);
        check("midrst_full", 32'(tx_full), 32'd0);
        rst = 1'b0;
        sb.delete();
        frames_expected -= 2;
        d0 = done_total;
        lowc = 0;
        repeat (1500) begin
            @(negedge clk);
            if (tx !== 1'b1) lowc++;
        end
        check("no_tx_after_rst", 32'(lowc), 32'd0);
        check("no_done_after_rst", 32'(done_total - d0), 32'd0);

        // Two stop bits on the SB_TICK=32 instance: 0x81 ends data high, so
        // the last rise is the start of bit 7; done follows 64 + 128 clk later.
        @(negedge clk);
        w_data32 = 8'h81;
        wr32 = 1'b1;
        @(negedge clk);
        wr32 = 1'b0;
        @(negedge clk);
        check("sb32_start", 32'(tx32), 32'd0);
        prev = 1'b0;
        last_rise = 0;
        done_at = 0;
        for (int k = 1; k <= 900; k++) begin
            @(negedge clk);
            if (tx32 === 1'b1 && prev === 1'b0) last_rise = k;
            prev = tx32;
            if (done32 === 1'b1) begin
                done_at = k;
                break;
            end
        end
        check("sb32_done_seen", 32'(done_at > 0), 32'd1);
        check("sb32_bit7_plus_stop", 32'(done_at - last_rise), 32'd192);
        check_range("sb32_frame_len", done_at, 701, 704);
        check("sb32_busy_at_done", 32'(busy32), 32'd0);

        repeat (10) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        check("done_total", 32'(done_total), 32'(frames_expected));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

Buffered UART transmit path: the transmit counterpart of the FIFO-backed UART receive path. Bytes written by the host are queued in an internal FIFO and serialized on `tx` as 8N1-style frames: start bit, `DBIT` data bits LSB first, then a stop period. Bit timing comes from the shared 16x-oversampling baud tick produced by the existing `timer_input` baud generator. The block sits beside the receiver in the UART top level, sharing `clk`, `rst` and the baud tick.

## Interface
- `DBIT`, 8: data bits per frame.
- `SB_TICK`, 16: stop-period length in `s_tick`s (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- `FIFO_AW`, 2: FIFO address width; depth = 2**FIFO_AW (default 4).
- `clk`  in  1  system clock; only clock.
- `rst`  in  1  synchronous, active-high reset.
- `s_tick`  in  1  one-`clk` pulse at 16x baud rate, from the baud generator.
- `w_data`  in  DBIT  byte to queue.
- `wr_uart`  in  1  write strobe; one byte is queued per asserted cycle.
- `tx_full`  out  1  FIFO full; writes are ignored while high.
- `tx_empty`  out  1  FIFO empty.
- `tx_busy`  out  1  FSM not in IDLE.
- `tx_done_tick`  out  1  one-`clk` pulse at the end of each frame's stop period.
- `tx`  out  1  serial line, registered, idles high.

## Operation
- FIFO is first-word-fall-through: the head word is valid whenever `tx_empty`=0.
- Push: `wr_uart` && !`tx_full`.
- Pop: FSM IDLE→START only.
- Write while full is dropped silently, with no state change. This holds even if a pop occurs in the same cycle.
- Simultaneous push and pop on a non-empty, non-full FIFO leaves the count unchanged.
- FSM states: IDLE, START, DATA, STOP.
- Registers: `s_cnt` (4 bits, or wide enough for SB_TICK-1), `n_cnt` (clog2 DBIT), shift register `b_reg` (DBIT), `tx_reg`.
- IDLE:
  - `tx_reg`=1; `s_tick` is ignored.
  - If `tx_empty`=0: load `b_reg` with the head word, pop, `s_cnt`←0, `tx_reg`←0, go to START.
- START:
  - `tx_reg`=0.
  - On `s_tick`: if `s_cnt`=15, then `s_cnt`←0, `n_cnt`←0, go to DATA. Otherwise `s_cnt`++.
- DATA:
  - `tx_reg`=`b_reg[0]`.
  - On `s_tick` with `s_cnt`=15: `b_reg`←`b_reg`>>1, `s_cnt`←0.
    - If `n_cnt`=DBIT-1, go to STOP (`tx_reg`←1).
    - Otherwise `n_cnt`++.
  - On any other `s_tick`: `s_cnt`++.
- STOP:
  - `tx_reg`=1.
  - On `s_tick`: if `s_cnt`=SB_TICK-1, then pulse `tx_done_tick`, go to IDLE. Otherwise `s_cnt`++.
- Back-to-back frames: IDLE holds for exactly one `clk` before the next start bit if the FIFO is non-empty.
- Reset, including mid-frame: next cycle state=IDLE, FIFO flushed, counters cleared.
- Reset values: `tx`=1, `tx_full`=0, `tx_empty`=1, `tx_busy`=0, `tx_done_tick`=0.

## Timing
- Write latency into an idle block:
  - `wr_uart` at cycle 0.
  - `tx_empty`=0 at cycle 1.
  - FSM leaves IDLE at the cycle 1→2 edge; `tx`=0 and `tx_busy`=1 at cycle 2.
  - Pop completes at cycle 2; `tx_empty`=1 at cycle 2 if no other data is queued.
- Bit periods: start bit = 16 `s_tick`s plus the sub-tick phase offset at entry. Each data bit = exactly 16 ticks. Stop = SB_TICK ticks.
- Frame = (1+DBIT)·16 + SB_TICK ticks, plus up to one tick period of entry phase.
- `tx_done_tick` is asserted in the cycle after the final stop `s_tick` is sampled. `tx_busy` is 0 in that same cycle.
- `tx_full`/`tx_empty` are registered flags that update the cycle after the push/pop.

## Structure
- Shared package `uart_pkg`:
  - FSM state encoding (IDLE=0, START=1, DATA=2, STOP=3).
  - Default `DBIT`/`SB_TICK` localparams, also used by `uart_rx`.
  - `OVERSAMPLE`=16 constant.
- One sub-module, `uart_sync_fifo`:
  - Parameterized FWFT synchronous FIFO (data width, address width).
  - Ports: din, wr_en, rd_en, dout, full, empty.
  - Reusable for the receive side.
- FSM and datapath live in `uart_tx_buffered`.

## Test plan
- Reset, then idle 200 cycles -> `tx`=1, `tx_empty`=1, `tx_busy`=0, no `tx_done_tick`.
- `s_tick` every 4 clk; write 0xA5 -> `tx`=0 two cycles after `wr_uart`. Line then carries 0,1,0,1,0,0,1,0,1,1, each bit 64 clk (±3 on the start bit). One `tx_done_tick` follows.
- Write 0x00, 0xFF, 0x3C in consecutive cycles -> three frames decoded in order by a reference receiver model. Exactly one idle-high `clk` between each stop and the next start. `tx_empty` rises when the third frame starts.
- Fill FIFO (4 writes while the first is still queued), then write 0x77 -> `tx_full`=1 during the 5th write. 0x77 never appears on `tx`, and the 4 accepted bytes are transmitted.
- `SB_TICK`=32, write 0x81 -> stop period = 128 clk before `tx_done_tick`.
- Assert `rst` for 1 cycle mid-DATA of the 2nd of 3 queued bytes -> `tx`=1 next cycle, FIFO empty, and no further frames are sent.
